// File: rtl/soc_wb_pkg.sv
// Shared Wishbone cycle/burst type codes and the bridge FSM state type.
package soc_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SINGLE,
    ST_BURST
  } wb_state_e;

endpackage

// File: rtl/soc_wb_burst_adr_gen.sv
// Next word address of an incrementing Wishbone burst: linear, or wrapping
// within an aligned 4/8/16-word window.
module soc_wb_burst_adr_gen
  import soc_wb_pkg::*;
#(
  parameter int WORD_AW = 30
) (
  input  logic [WORD_AW-1:0] cur_adr_i,
  input  logic [1:0]         bte_i,
  output logic [WORD_AW-1:0] next_adr_o
);

  logic [WORD_AW-1:0] incAdr;
  logic [WORD_AW-1:0] wrapMask;

  // Bits under wrapMask take the incremented value; the rest stay put, so a
  // wrap burst never leaves its aligned window and a linear one rolls over.
  always_comb begin
    incAdr = cur_adr_i + WORD_AW'(1);
    case (bte_i)
      BTE_WRAP4:  wrapMask = WORD_AW'(3);
      BTE_WRAP8:  wrapMask = WORD_AW'(7);
      BTE_WRAP16: wrapMask = WORD_AW'(15);
      default:    wrapMask = '1;
    endcase
    next_adr_o = (cur_adr_i & ~wrapMask) | (incAdr & wrapMask);
  end

endmodule

// File: rtl/soc_wb2sram_sp.sv
// Wishbone B3 slave bridging classic and incrementing-burst cycles onto a
// single-port SRAM with one cycle of read latency.
module soc_wb2sram_sp
  import soc_wb_pkg::*;
#(
  parameter  int AW            = 32,
  parameter  int DW            = 32,
  parameter  int MEM_SIZE_BYTE = 'h8000,
  localparam int SW            = DW / 8,
  localparam int WORD_AW       = AW - (SW >> 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AW-1:0]      wb_adr_i,
  input  logic [DW-1:0]      wb_dat_i,
  input  logic [SW-1:0]      wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic [2:0]         wb_cti_i,
  input  logic [1:0]         wb_bte_i,
  output logic [DW-1:0]      wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               sram_ce,
  output logic               sram_we,
  output logic               sram_oe,
  output logic [WORD_AW-1:0] sram_waddr,
  output logic [DW-1:0]      sram_din,
  output logic [SW-1:0]      sram_sel,
  input  logic [DW-1:0]      sram_dout
);

  localparam int               ADR_LSB   = $clog2(SW);
  localparam logic [WORD_AW:0] MEM_WORDS = (WORD_AW+1)'(MEM_SIZE_BYTE / SW);

  wb_state_e          state_q, state_d;
  logic [WORD_AW-1:0] curAdr_q, curAdr_d;
  logic [WORD_AW-1:0] nextAdr, wordAdr, sramAdr;
  logic               curOutOfRange, ackRaw, errRaw;

  assign wordAdr       = WORD_AW'(wb_adr_i >> ADR_LSB);
  assign curOutOfRange = {1'b0, curAdr_q} >= MEM_WORDS;

  soc_wb_burst_adr_gen #(.WORD_AW(WORD_AW)) u_adr_gen (
    .cur_adr_i  (curAdr_q),
    .bte_i      (wb_bte_i),
    .next_adr_o (nextAdr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      curAdr_q <= '0;
    end else begin
      state_q  <= state_d;
      curAdr_q <= curAdr_d;
    end
  end

  // Burst reads present the following word during each beat so the SRAM's
  // one-cycle latency lines up with the next strobe; writes use the current one.
  always_comb begin
    state_d  = state_q;
    curAdr_d = curAdr_q;
    sramAdr  = curAdr_q;
    ackRaw   = 1'b0;
    errRaw   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sramAdr = wordAdr;
        if (wb_cyc_i && wb_stb_i) begin
          curAdr_d = wordAdr;
          state_d  = (wb_cti_i == CTI_INCR) ? ST_BURST : ST_SINGLE;
        end
      end
      ST_SINGLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          errRaw  = curOutOfRange;
          ackRaw  = ~curOutOfRange;
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (wb_cyc_i && wb_stb_i) begin
          errRaw   = curOutOfRange;
          ackRaw   = ~curOutOfRange;
          curAdr_d = nextAdr;
          if (!wb_we_i) sramAdr = nextAdr;
          if (wb_cti_i != CTI_INCR || curOutOfRange) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!wb_cyc_i) state_d = ST_IDLE;
  end

  assign wb_ack_o   = ackRaw & ~rst;
  assign wb_err_o   = errRaw & ~rst;
  assign wb_dat_o   = wb_ack_o ? sram_dout : '0;
  assign sram_ce    = ~rst & wb_cyc_i & (wb_stb_i | (state_q == ST_BURST));
  assign sram_we    = wb_ack_o & wb_we_i;
  assign sram_oe    = sram_ce & ~sram_we;
  assign sram_waddr = sramAdr;
  assign sram_din   = wb_dat_i;
  assign sram_sel   = wb_sel_i;

endmodule

// File: tb/tb_soc_wb2sram_sp.sv
// Self-checking bench: soc_wb2sram_sp against a behavioural SRAM and a
// word-array reference memory driven by the Wishbone transfer rules.
module tb_soc_wb2sram_sp;
  import soc_wb_pkg::*;

  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int WORD_AW   = 30;
  localparam int MEM_WORDS = 'h8000 / 4;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0]      wb_adr_i;
  logic [DW-1:0]      wb_dat_i;
  logic [3:0]         wb_sel_i;
  logic               wb_we_i, wb_cyc_i, wb_stb_i;
  logic [2:0]         wb_cti_i;
  logic [1:0]         wb_bte_i;
  logic [DW-1:0]      wb_dat_o;
  logic               wb_ack_o, wb_err_o;
  logic               sram_ce, sram_we, sram_oe;
  logic [WORD_AW-1:0] sram_waddr;
  logic [DW-1:0]      sram_din;
  logic [3:0]         sram_sel;
  logic [DW-1:0]      sram_dout;

  int checks = 0;
  int errors = 0;

  logic        memInit;
  int          writeCount, badWrites;
  logic [31:0] sramMem [MEM_WORDS];
  logic [31:0] refMem  [MEM_WORDS];

  logic        obsAck, obsErr, obsCe, obsWe, obsOe;
  logic [31:0] obsDat;
  logic        c1Term, c1Oe, c2Ack, c2Err, c2We, c2Oe;
  logic [31:0] c2Dat;
  logic [31:0] bData [16];
  logic        bAck  [16];
  logic        bErr  [16];
  logic [31:0] bDat  [16];
  logic        firstTerm, postTerm;
  int          gapTerm;

  always #5 clk = ~clk;

  soc_wb2sram_sp #(.AW(AW), .DW(DW), .MEM_SIZE_BYTE('h8000)) dut (
    .clk(clk), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_oe(sram_oe), .sram_waddr(sram_waddr),
    .sram_din(sram_din), .sram_sel(sram_sel), .sram_dout(sram_dout)
  );

  // Behavioural single-port SRAM: registered read, byte-masked write.
  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < MEM_WORDS; i++) sramMem[i] <= 32'h0;
      writeCount <= 0;
      badWrites  <= 0;
      sram_dout  <= 32'h0;
    end else if (sram_ce) begin
      if (sram_we) begin
        if ({2'b00, sram_waddr} < MEM_WORDS) begin
          for (int b = 0; b < 4; b++)
            if (sram_sel[b]) sramMem[sram_waddr[12:0]][8*b +: 8] <= sram_din[8*b +: 8];
          writeCount <= writeCount + 1;
        end else begin
          badWrites <= badWrites + 1;
        end
      end else begin
        sram_dout <= ({2'b00, sram_waddr} < MEM_WORDS) ? sramMem[sram_waddr[12:0]] : 32'h0;
      end
    end
  end

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] nw,
                                             input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Word visited on beat k of a burst starting at 'start'.
  function automatic int burstAddr(input int start, input logic [1:0] bte, input int k);
    int n;
    n = (bte == BTE_WRAP4) ? 4 : (bte == BTE_WRAP8) ? 8 : (bte == BTE_WRAP16) ? 16 : 0;
    if (n == 0) return start + k;
    return (start / n) * n + ((start + k) % n);
  endfunction

  task automatic driveCycle(input logic r, input logic cyc, input logic stb, input logic we,
                            input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                            input logic [2:0] cti, input logic [1:0] bte);
    @(posedge clk);
    #1;
    rst = r; wb_cyc_i = cyc; wb_stb_i = stb; wb_we_i = we; wb_adr_i = adr;
    wb_dat_i = dat; wb_sel_i = sel; wb_cti_i = cti; wb_bte_i = bte;
    @(negedge clk);
    obsAck = wb_ack_o; obsErr = wb_err_o; obsDat = wb_dat_o;
    obsCe = sram_ce; obsWe = sram_we; obsOe = sram_oe;
  endtask

  task automatic classicOp(input logic we, input int word, input logic [31:0] dat,
                           input logic [3:0] sel);
    driveCycle(1'b0, 1'b1, 1'b1, we, 32'(word) << 2, dat, sel, CTI_CLASSIC, BTE_LINEAR);
    c1Term = obsAck | obsErr;
    c1Oe   = obsOe;
    driveCycle(1'b0, 1'b1, 1'b1, we, 32'(word) << 2, dat, sel, CTI_CLASSIC, BTE_LINEAR);
    c2Ack = obsAck; c2Err = obsErr; c2Dat = obsDat; c2We = obsWe; c2Oe = obsOe;
    driveCycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CLASSIC, BTE_LINEAR);
  endtask

  task automatic burstOp(input logic we, input int start, input logic [1:0] bte,
                         input int n, input int gapAfter, input int gapLen);
    gapTerm = 0;
    driveCycle(1'b0, 1'b1, 1'b1, we, 32'(start) << 2, bData[0], 4'hF, CTI_INCR, bte);
    firstTerm = obsAck | obsErr;
    for (int k = 0; k < n; k++) begin
      driveCycle(1'b0, 1'b1, 1'b1, we, 32'(burstAddr(start, bte, k)) << 2, bData[k], 4'hF,
                 (k == n - 1) ? CTI_EOB : CTI_INCR, bte);
      bAck[k] = obsAck; bErr[k] = obsErr; bDat[k] = obsDat;
      if (k == gapAfter) begin
        for (int g = 0; g < gapLen; g++) begin
          driveCycle(1'b0, 1'b1, 1'b0, we, 32'(burstAddr(start, bte, k + 1)) << 2,
                     bData[(k + 1) % 16], 4'hF, CTI_INCR, bte);
          if (obsAck || obsErr) gapTerm++;
        end
      end
    end
    driveCycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, CTI_INCR, bte);
    postTerm = obsAck | obsErr;
    driveCycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CLASSIC, BTE_LINEAR);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++)
      driveCycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CLASSIC, BTE_LINEAR);
    checks++;
    if ({obsAck, obsErr, obsCe, obsWe, obsOe} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000", {obsAck, obsErr, obsCe, obsWe, obsOe});
    end
    checks++;
    if (obsDat !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_dat: got %h expected 00000000", obsDat);
    end
    driveCycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 32'h12345678, 4'hF, CTI_INCR, BTE_LINEAR);
    checks++;
    if ({obsAck, obsErr, obsCe, obsWe} !== 4'b0) begin
      errors++; $display("[TB] FAIL reset_wins: got %b expected 0000", {obsAck, obsErr, obsCe, obsWe});
    end
    memInit = 1'b0;
    driveCycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CLASSIC, BTE_LINEAR);
  endtask

  task automatic test_classic();
    classicOp(1'b1, 4, 32'hDEADBEEF, 4'hF);
    refMem[4] = mergeBytes(refMem[4], 32'hDEADBEEF, 4'hF);
    checks++;
    if ({c1Term, c2Ack, c2Err, c2We, c2Oe} !== 5'b01010) begin
      errors++;
      $display("[TB] FAIL classic_wr_handshake: got %b expected 01010", {c1Term, c2Ack, c2Err, c2We, c2Oe});
    end
    classicOp(1'b0, 4, 32'h0, 4'hF);
    checks++;
    if ({c1Term, c2Ack, c2Err, c1Oe} !== 4'b0101) begin
      errors++; $display("[TB] FAIL classic_rd_handshake: got %b expected 0101", {c1Term, c2Ack, c2Err, c1Oe});
    end
    checks++;
    if (c2Dat !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL classic_rd_data: got %h expected deadbeef", c2Dat);
    end
    classicOp(1'b1, 12, 32'h11223344, 4'hF);
    refMem[12] = mergeBytes(refMem[12], 32'h11223344, 4'hF);
    classicOp(1'b1, 12, 32'h0000AB00, 4'b0010);
    refMem[12] = mergeBytes(refMem[12], 32'h0000AB00, 4'b0010);
    classicOp(1'b0, 12, 32'h0, 4'hF);
    checks++;
    if (c2Dat !== 32'h1122AB44) begin
      errors++; $display("[TB] FAIL byte_lane: got %h expected 1122ab44", c2Dat);
    end
  endtask

  task automatic test_random_classic();
    for (int i = 0; i < 24; i++) begin
      logic we, oor;
      int word, wc0, expWr;
      logic [31:0] dat, expDat;
      logic [3:0] sel;
      we   = 1'($urandom_range(0, 1));
      word = ($urandom_range(0, 7) == 0) ? MEM_WORDS + int'($urandom_range(0, 64))
                                          : int'($urandom_range(0, MEM_WORDS - 1));
      oor    = (word >= MEM_WORDS);
      sel    = 4'($urandom_range(1, 15));
      dat    = $urandom();
      expDat = oor ? 32'h0 : refMem[word];
      expWr  = (we && !oor) ? 1 : 0;
      wc0    = writeCount;
      classicOp(we, word, dat, sel);
      checks++;
      if ({c1Term, c2Ack, c2Err} !== {1'b0, ~oor, oor}) begin
        errors++;
        $display("[TB] FAIL rand_handshake word %0d: got %b expected %b", word,
                 {c1Term, c2Ack, c2Err}, {1'b0, ~oor, oor});
      end
      if (!we) begin
        checks++;
        if (c2Dat !== expDat) begin
          errors++; $display("[TB] FAIL rand_rd_data word %0d: got %h expected %h", word, c2Dat, expDat);
        end
      end
      checks++;
      if (writeCount - wc0 !== expWr) begin
        errors++; $display("[TB] FAIL rand_wr_count: got %0d expected %0d", writeCount - wc0, expWr);
      end
      if (we && !oor) refMem[word] = mergeBytes(refMem[word], dat, sel);
    end
  endtask

  task automatic test_bursts();
    int          starts [5];
    logic [1:0]  btes   [5];
    int          lens   [5];
    for (int h = 0; h < 2; h++) begin
      for (int k = 0; k < 16; k++) bData[k] = $urandom();
      burstOp(1'b1, 16 * h, BTE_LINEAR, 16, -1, 0);
      for (int k = 0; k < 16; k++) begin
        checks++;
        if ({bAck[k], bErr[k]} !== 2'b10) begin
          errors++; $display("[TB] FAIL burst_wr_beat %0d: got %b expected 10", k, {bAck[k], bErr[k]});
        end
        refMem[16 * h + k] = bData[k];
      end
    end
    for (int k = 0; k < 8; k++) bData[k] = $urandom();
    burstOp(1'b1, 21, BTE_WRAP8, 8, -1, 0);
    for (int k = 0; k < 8; k++) refMem[burstAddr(21, BTE_WRAP8, k)] = bData[k];
    starts = '{8, 14, 6, 0, 16};
    btes   = '{BTE_LINEAR, BTE_WRAP4, BTE_WRAP8, BTE_WRAP16, BTE_LINEAR};
    lens   = '{4, 4, 8, 16, 8};
    starts[3] = int'($urandom_range(0, 31));
    for (int t = 0; t < 5; t++) begin
      burstOp(1'b0, starts[t], btes[t], lens[t], -1, 0);
      checks++;
      if ({firstTerm, postTerm} !== 2'b00) begin
        errors++; $display("[TB] FAIL burst_edges %0d: got %b expected 00", t, {firstTerm, postTerm});
      end
      for (int k = 0; k < lens[t]; k++) begin
        int a;
        a = burstAddr(starts[t], btes[t], k);
        checks++;
        if ({bAck[k], bErr[k], bDat[k]} !== {2'b10, refMem[a]}) begin
          errors++;
          $display("[TB] FAIL burst_rd %0d beat %0d word %0d: got %b/%h expected 10/%h",
                   t, k, a, {bAck[k], bErr[k]}, bDat[k], refMem[a]);
        end
      end
    end
  endtask

  task automatic test_wait_states();
    for (int k = 0; k < 4; k++) bData[k] = $urandom();
    burstOp(1'b1, 100, BTE_LINEAR, 4, int'($urandom_range(0, 2)), 3);
    checks++;
    if (gapTerm !== 0) begin
      errors++; $display("[TB] FAIL wr_gap_term: got %0d expected 0", gapTerm);
    end
    for (int k = 0; k < 4; k++) refMem[100 + k] = bData[k];
    for (int r = 0; r < 2; r++) begin
      int s;
      s = (r == 0) ? 8 : 100;
      burstOp(1'b0, s, BTE_LINEAR, 4, 1, 2);
      checks++;
      if (gapTerm !== 0) begin
        errors++; $display("[TB] FAIL rd_gap_term: got %0d expected 0", gapTerm);
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if ({bAck[k], bDat[k]} !== {1'b1, refMem[s + k]}) begin
          errors++;
          $display("[TB] FAIL gap_rd beat %0d: got %b/%h expected 1/%h", k, bAck[k], bDat[k], refMem[s + k]);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    int wc0;
    wc0 = writeCount;
    classicOp(1'b0, MEM_WORDS, 32'h0, 4'hF);
    checks++;
    if ({c1Term, c2Ack, c2Err, c2Dat} !== {3'b001, 32'h0}) begin
      errors++; $display("[TB] FAIL oor_read: got %b/%h expected 001/0", {c1Term, c2Ack, c2Err}, c2Dat);
    end
    classicOp(1'b1, MEM_WORDS, 32'hCAFEF00D, 4'hF);
    checks++;
    if ({c2Ack, c2Err, c2We} !== 3'b010) begin
      errors++; $display("[TB] FAIL oor_write: got %b expected 010", {c2Ack, c2Err, c2We});
    end
    burstOp(1'b0, MEM_WORDS - 1, BTE_LINEAR, 2, -1, 0);
    checks++;
    if ({bAck[0], bErr[0], bDat[0], bAck[1], bErr[1], postTerm} !== {2'b10, refMem[MEM_WORDS-1], 3'b010}) begin
      errors++;
      $display("[TB] FAIL oor_rd_burst: got %b%b/%h %b%b%b expected 10/%h 010", bAck[0], bErr[0], bDat[0],
               bAck[1], bErr[1], postTerm, refMem[MEM_WORDS-1]);
    end
    bData[0] = $urandom(); bData[1] = $urandom();
    burstOp(1'b1, MEM_WORDS - 1, BTE_LINEAR, 2, -1, 0);
    refMem[MEM_WORDS-1] = bData[0];
    checks++;
    if ({bAck[0], bErr[0], bAck[1], bErr[1]} !== 4'b1001) begin
      errors++; $display("[TB] FAIL oor_wr_burst: got %b expected 1001", {bAck[0], bErr[0], bAck[1], bErr[1]});
    end
    checks++;
    if ({writeCount - wc0, badWrites} !== {32'd1, 32'd0}) begin
      errors++; $display("[TB] FAIL oor_writes: got %0d/%0d expected 1/0", writeCount - wc0, badWrites);
    end
    classicOp(1'b0, MEM_WORDS - 1, 32'h0, 4'hF);
    checks++;
    if (c2Dat !== refMem[MEM_WORDS-1]) begin
      errors++; $display("[TB] FAIL oor_last_word: got %h expected %h", c2Dat, refMem[MEM_WORDS-1]);
    end
  endtask

  task automatic test_cyc_drop();
    int wc0;
    wc0 = writeCount;
    for (int k = 0; k < 4; k++) bData[k] = $urandom();
    driveCycle(1'b0, 1'b1, 1'b1, 1'b1, 32'(40) << 2, bData[0], 4'hF, CTI_INCR, BTE_LINEAR);
    for (int k = 0; k < 2; k++) begin
      driveCycle(1'b0, 1'b1, 1'b1, 1'b1, 32'(40 + k) << 2, bData[k], 4'hF, CTI_INCR, BTE_LINEAR);
      checks++;
      if (obsAck !== 1'b1) begin
        errors++; $display("[TB] FAIL drop_beat %0d: got ack %b expected 1", k, obsAck);
      end
    end
    driveCycle(1'b0, 1'b0, 1'b1, 1'b1, 32'(42) << 2, bData[2], 4'hF, CTI_INCR, BTE_LINEAR);
    checks++;
    if ({obsAck, obsErr, obsWe} !== 3'b000) begin
      errors++; $display("[TB] FAIL drop_no_term: got %b expected 000", {obsAck, obsErr, obsWe});
    end
    driveCycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CLASSIC, BTE_LINEAR);
    refMem[40] = bData[0];
    refMem[41] = bData[1];
    checks++;
    if (writeCount - wc0 !== 2) begin
      errors++; $display("[TB] FAIL drop_writes: got %0d expected 2", writeCount - wc0);
    end
    burstOp(1'b0, 40, BTE_LINEAR, 4, -1, 0);
    checks++;
    if (firstTerm !== 1'b0) begin
      errors++; $display("[TB] FAIL drop_idle: got %b expected 0", firstTerm);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bDat[k] !== refMem[40 + k]) begin
        errors++; $display("[TB] FAIL drop_mem word %0d: got %h expected %h", 40 + k, bDat[k], refMem[40 + k]);
      end
    end
  endtask

  task automatic test_reset_in_burst();
    driveCycle(1'b0, 1'b1, 1'b1, 1'b0, 32'(8) << 2, 32'h0, 4'hF, CTI_INCR, BTE_LINEAR);
    driveCycle(1'b0, 1'b1, 1'b1, 1'b0, 32'(8) << 2, 32'h0, 4'hF, CTI_INCR, BTE_LINEAR);
    driveCycle(1'b1, 1'b1, 1'b1, 1'b0, 32'(9) << 2, 32'h0, 4'hF, CTI_INCR, BTE_LINEAR);
    checks++;
    if ({obsAck, obsErr, obsCe, obsWe, obsOe, obsDat} !== 37'h0) begin
      errors++;
      $display("[TB] FAIL rst_in_burst: got %b/%h expected 00000/0", {obsAck, obsErr, obsCe, obsWe, obsOe}, obsDat);
    end
    driveCycle(1'b0, 1'b1, 1'b1, 1'b0, 32'(20) << 2, 32'h0, 4'hF, CTI_INCR, BTE_LINEAR);
    checks++;
    if ({obsAck, obsErr} !== 2'b00) begin
      errors++; $display("[TB] FAIL rst_back_idle: got %b expected 00", {obsAck, obsErr});
    end
    driveCycle(1'b0, 1'b1, 1'b1, 1'b0, 32'(20) << 2, 32'h0, 4'hF, CTI_EOB, BTE_LINEAR);
    checks++;
    if ({obsAck, obsDat} !== {1'b1, refMem[20]}) begin
      errors++; $display("[TB] FAIL rst_resume: got %b/%h expected 1/%h", obsAck, obsDat, refMem[20]);
    end
    driveCycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, CTI_CLASSIC, BTE_LINEAR);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; memInit = 1'b1;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = CTI_CLASSIC; wb_bte_i = BTE_LINEAR;
    for (int i = 0; i < MEM_WORDS; i++) refMem[i] = 32'h0;
    test_reset();
    test_classic();
    test_random_classic();
    test_bursts();
    test_wait_states();
    test_out_of_range();
    test_cyc_drop();
    test_reset_in_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
